// File: rtl/plab5_mcore_proc_resp_filter.sv
// -----------------------------------------------------------------------------
// plab5_mcore_proc_resp_filter
//
// Purpose:
//   Buffered security filter between the memory-response network and one
//   processor's response port. Each response is label-checked once, when it
//   is accepted: allowed iff resp_sec_level <= proc_sec_level (unsigned).
//   Allowed responses are queued unchanged. Disallowed responses are queued
//   with the data field zeroed (p_drop_mode = 0) or discarded (p_drop_mode = 1).
//   Every accepted disallowed response bumps a saturating violation counter.
//
// Parameters:
//   p_opaque_nbits  opaque field width
//   p_data_nbits    data field width
//   p_level_nbits   security label width (larger = more secret)
//   p_num_entries   queue depth, power of two, >= 2
//   p_drop_mode     0 = scrub disallowed responses, 1 = drop them
//   p_cnt_nbits     violation counter width
//   resp_nbits      message width, layout {type[3], opaque, len[2], data}
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   net_resp_*       val/rdy/msg from the memory-response network
//   resp_sec_level   label of the current net_resp_msg
//   proc_sec_level   processor's current label
//   proc_resp_*      val/rdy/msg to the processor
//   viol_clr         clears the violation counter
//   viol_count       saturating count of disallowed responses
// -----------------------------------------------------------------------------
module plab5_mcore_proc_resp_filter #(
  parameter int unsigned  p_opaque_nbits = 8,
  parameter int unsigned  p_data_nbits   = 32,
  parameter int unsigned  p_level_nbits  = 2,
  parameter int unsigned  p_num_entries  = 4,
  parameter int unsigned  p_drop_mode    = 0,
  parameter int unsigned  p_cnt_nbits    = 8,
  localparam int unsigned resp_nbits     = 3 + p_opaque_nbits + 2 + p_data_nbits
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     net_resp_val,
  output logic                     net_resp_rdy,
  input  logic [resp_nbits-1:0]    net_resp_msg,

  input  logic [p_level_nbits-1:0] resp_sec_level,
  input  logic [p_level_nbits-1:0] proc_sec_level,

  output logic                     proc_resp_val,
  input  logic                     proc_resp_rdy,
  output logic [resp_nbits-1:0]    proc_resp_msg,

  input  logic                     viol_clr,
  output logic [p_cnt_nbits-1:0]   viol_count
);

  localparam int unsigned             c_ptr_nbits = $clog2(p_num_entries);
  localparam logic [c_ptr_nbits:0]    c_depth     = (c_ptr_nbits + 1)'(p_num_entries);
  localparam logic [p_cnt_nbits-1:0]  c_cnt_max   = '1;

  // Queue storage and bookkeeping
  logic [resp_nbits-1:0]    r_buf [p_num_entries];
  logic [c_ptr_nbits-1:0]   r_head;
  logic [c_ptr_nbits-1:0]   r_tail;
  logic [c_ptr_nbits:0]     r_count;
  logic [p_cnt_nbits-1:0]   r_viol;

  logic                     w_full;
  logic                     w_empty;
  logic                     w_accept;
  logic                     w_allowed;
  logic                     w_viol;
  logic                     w_enq;
  logic                     w_deq;
  logic [resp_nbits-1:0]    w_enq_msg;

  // Ready depends only on registered occupancy, never on proc_resp_rdy, so
  // a full queue stays not-ready for the cycle in which it drains an entry.
  assign w_full    = (r_count == c_depth);
  assign w_empty   = (r_count == '0);
  assign w_accept  = net_resp_val && !w_full;
  assign w_allowed = (resp_sec_level <= proc_sec_level);
  assign w_viol    = w_accept && !w_allowed;
  assign w_deq     = !w_empty && proc_resp_rdy;

  // In drop mode a disallowed response is consumed from the network but
  // never reaches the queue.
  assign w_enq     = w_accept && (w_allowed || (p_drop_mode == 0));

  // Scrubbing clears only the data field; type/opaque/len survive so the
  // processor still sees a completion for its request.
  always_comb begin
    w_enq_msg = net_resp_msg;
    if (!w_allowed) begin
      w_enq_msg[p_data_nbits-1:0] = '0;
    end
  end

  // Payload storage carries no reset: entries are only visible through
  // r_count, which reset clears.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_buf[r_tail] <= w_enq_msg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_deq) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear wins over the stored value but not over a same-cycle violation,
  // which is counted on top of the cleared value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_viol <= '0;
    end else if (viol_clr) begin
      r_viol <= p_cnt_nbits'(w_viol);
    end else if (w_viol && (r_viol != c_cnt_max)) begin
      r_viol <= r_viol + 1'b1;
    end
  end

  assign net_resp_rdy  = !w_full;
  assign proc_resp_val = !w_empty;
  assign proc_resp_msg = r_buf[r_head];
  assign viol_count    = r_viol;

endmodule

// File: doc/plab5_mcore_proc_resp_filter.md
# plab5_mcore_proc_resp_filter

Parametrised, buffered security filter between the memory-response network and one processor's response port. Each response carries a multi-bit security label, checked against the processor's label when it is accepted. Allowed responses pass unchanged. Disallowed responses are either scrubbed (data zeroed) or dropped, depending on mode. Violations are counted for the security monitor.

## Interface
Parameters:
- p_opaque_nbits, 8, memory message opaque field width (o)
- p_data_nbits, 32, memory message data field width (d)
- p_level_nbits, 2, security label width; numerically larger label is more secret
- p_num_entries, 4, response queue depth; power of two, >= 2
- p_drop_mode, 0, 0 = scrub disallowed responses, 1 = drop them
- p_cnt_nbits, 8, violation counter width
- resp_nbits, local constant = 3+o+2+d; message layout {type[3], opaque[o], len[2], data[d]}, data in the LSBs

Ports:
- clk, in, 1, clock
- reset, in, 1, synchronous active-high reset
- net_resp_val, in, 1, network response valid
- net_resp_rdy, out, 1, filter can accept a response
- net_resp_msg, in, resp_nbits, network response message
- resp_sec_level, in, p_level_nbits, label of the current net_resp_msg
- proc_sec_level, in, p_level_nbits, processor's current label
- proc_resp_val, out, 1, response valid to processor
- proc_resp_rdy, in, 1, processor accepts response
- proc_resp_msg, out, resp_nbits, response message to processor
- viol_clr, in, 1, clears the violation counter
- viol_count, out, p_cnt_nbits, saturating count of disallowed responses

## Operation
- Accept: net_resp_val && net_resp_rdy.
- Check at accept, using that cycle's labels: allowed iff resp_sec_level <= proc_sec_level (unsigned).
  - A later change of proc_sec_level does not re-check queued entries.
- Allowed response: enqueued unchanged.
- Disallowed response, p_drop_mode=0: enqueued with data field forced to 0. Type, opaque and len are unchanged, so the processor never waits forever.
- Disallowed response, p_drop_mode=1: consumed and discarded. Not enqueued.
- Queue: circular buffer of p_num_entries.
  - Head and tail pointers are log2(p_num_entries) bits and wrap modulo depth.
  - An occupancy counter of log2(p_num_entries)+1 bits distinguishes full from empty.
- net_resp_rdy = !full. It applies in both modes and does not depend on proc_resp_rdy (no combinational rdy path).
- proc_resp_val = !empty. proc_resp_msg = head entry; it holds stable while val && !rdy.
- Dequeue: proc_resp_val && proc_resp_rdy.
- Simultaneous enqueue and dequeue (not full): occupancy unchanged, both pointers advance.
- Violation counter:
  - Increments by 1 on each accepted disallowed response.
  - Saturates at 2^p_cnt_nbits-1.
  - viol_clr sets it to 0. viol_clr with a violation in the same cycle gives 1.
- Reset:
  - Pointers and occupancy go to 0, so proc_resp_val=0 and net_resp_rdy=1 in the first cycle after reset.
  - viol_count goes to 0. Queued entries are discarded.
  - proc_resp_msg is don't-care while proc_resp_val=0.
  - Reset mid-transfer discards everything. No partial message is ever presented.

## Timing
- Latency: a response accepted in cycle N appears on proc_resp_val in cycle N+1 at the earliest. There is no bypass path.
- Throughput: one response per cycle sustained when proc_resp_rdy=1.
- Full queue: net_resp_rdy=0 in that cycle, even if a dequeue occurs. It returns to 1 in the cycle after the dequeue.
- viol_count updates in the cycle after the violating accept.
- Dropped responses in mode 1 never change queue state, but they do update viol_count.

## Test plan
- Reset, then labels resp=1, proc=1, msg data 0xDEADBEEF, opaque 0x05 -> proc_resp_val rises next cycle with the identical msg; viol_count=0.
- Mode 0, resp=3, proc=1, data 0x12345678, opaque 0x2A -> delivered with opaque 0x2A, data 0x00000000; viol_count=1.
- Mode 1, same stimulus -> nothing delivered, net_resp_rdy stays 1, viol_count=1. An allowed message sent next is delivered alone.
- Hold proc_resp_rdy=0, send 4 allowed messages (depth 4) -> net_resp_rdy=0 after the 4th. Release rdy -> messages are delivered in order, and rdy returns 1 the cycle after the first dequeue. Push 8 more to exercise pointer wrap.
- p_cnt_nbits=2, 5 violations -> viol_count saturates at 3. Assert viol_clr in the same cycle as a 6th violation -> viol_count=1.
- Assert reset with 3 entries queued -> next cycle proc_resp_val=0, net_resp_rdy=1, viol_count=0. A subsequent message is delivered correctly.
